// File: rtl/vend_input_cond.sv
// vend_input_cond: conditions the five raw board buttons (nickel, dime,
// quarter, soda, diet) into clean, single-cycle, mutually exclusive request
// pulses for the vending FSM. Each button is synchronized, debounced and
// rise-detected into a pending flag. A small arbiter then issues the pending
// requests one at a time, in priority order, with a programmable idle gap
// between successive pulses.
module vend_input_cond #(
  parameter int DB_CYCLES  = 16,
  parameter int CNT_W      = 5,
  parameter int GAP_CYCLES = 2
) (
  input  logic CLK,
  input  logic rst,
  input  logic btn_ni,
  input  logic btn_di,
  input  logic btn_qu,
  input  logic btn_soda,
  input  logic btn_diet,
  input  logic en,
  output logic ni,
  output logic di,
  output logic qu,
  output logic soda,
  output logic diet,
  output logic lost
);

  localparam int NUM_BTN = 5;

  // Bit positions of each button inside the internal per-button vectors
  localparam int B_NI   = 0;
  localparam int B_DI   = 1;
  localparam int B_QU   = 2;
  localparam int B_SODA = 3;
  localparam int B_DIET = 4;

  typedef enum logic {
    ST_IDLE,
    ST_GAP
  } arb_state_e;

  logic [NUM_BTN-1:0] btn_raw;
  logic [NUM_BTN-1:0] s1;
  logic [NUM_BTN-1:0] s2;
  logic [NUM_BTN-1:0] db;
  logic [NUM_BTN-1:0] db_next;
  logic [NUM_BTN-1:0] rise;
  logic [NUM_BTN-1:0] pend;
  logic [NUM_BTN-1:0] pend_next;
  logic [NUM_BTN-1:0] grant;
  logic [NUM_BTN-1:0] pulse;
  logic               lost_set;
  logic [3:0]         gap_cnt;
  logic [3:0]         gap_cnt_next;
  arb_state_e         state;
  arb_state_e         state_next;

  assign btn_raw = {btn_diet, btn_soda, btn_qu, btn_di, btn_ni};

  // Two-flop synchronizer chain bringing the asynchronous buttons into CLK
  always_ff @(posedge CLK or negedge rst) begin
    if (!rst) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= btn_raw;
      s2 <= s1;
    end
  end

  generate
    for (genvar i = 0; i < NUM_BTN; i++) begin : g_debounce
      logic [CNT_W-1:0] cnt;
      logic [CNT_W-1:0] cnt_next;
      logic             db_q;
      logic             db_d;

      // The debounced level only follows the synchronized input after it has
      // disagreed for DB_CYCLES consecutive edges; any agreement restarts it
      always_comb begin
        db_d     = db_q;
        cnt_next = '0;
        if (s2[i] == db_q) begin
          cnt_next = '0;
        end else if (cnt == CNT_W'(DB_CYCLES - 1)) begin
          db_d     = s2[i];
          cnt_next = '0;
        end else begin
          cnt_next = cnt + CNT_W'(1);
        end
      end

      // Debounced level and disagreement counter
      always_ff @(posedge CLK or negedge rst) begin
        if (!rst) begin
          db_q <= 1'b0;
          cnt  <= '0;
        end else begin
          db_q <= db_d;
          cnt  <= cnt_next;
        end
      end

      assign db[i]      = db_q;
      assign db_next[i] = db_d;
    end
  endgenerate

  // A rise is flagged on the same edge the debounced level goes 0 to 1
  assign rise = db_next & ~db;

  // Pending flags: flushed while disabled; a rise on an input whose earlier
  // request is still waiting (and not being granted now) is dropped and noted
  always_comb begin
    pend_next = '0;
    lost_set  = 1'b0;
    if (en) begin
      pend_next = (pend & ~grant) | rise;
      lost_set  = |(rise & pend & ~grant);
    end
  end

  // Pending flags, sticky lost flag and the registered request pulses
  always_ff @(posedge CLK or negedge rst) begin
    if (!rst) begin
      pend  <= '0;
      lost  <= 1'b0;
      pulse <= '0;
    end else begin
      pend  <= pend_next;
      pulse <= grant;
      if (lost_set) begin
        lost <= 1'b1;
      end
    end
  end

  // Arbiter state register and gap counter
  always_ff @(posedge CLK or negedge rst) begin
    if (!rst) begin
      state   <= ST_IDLE;
      gap_cnt <= '0;
    end else begin
      state   <= state_next;
      gap_cnt <= gap_cnt_next;
    end
  end

  // Arbiter next state: a grant opens a gap of GAP_CYCLES idle cycles, which
  // ends on the edge where the counter is seen at 1
  always_comb begin
    state_next   = state;
    gap_cnt_next = gap_cnt;
    case (state)
      ST_IDLE: begin
        if (|grant) begin
          gap_cnt_next = 4'(GAP_CYCLES);
          if (GAP_CYCLES > 0) begin
            state_next = ST_GAP;
          end
        end
      end
      ST_GAP: begin
        gap_cnt_next = gap_cnt - 4'd1;
        if (gap_cnt <= 4'd1) begin
          state_next = ST_IDLE;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Arbiter output: one-hot grant of the highest priority pending request
  // (quarter, dime, nickel, soda, diet) while idle and enabled
  always_comb begin
    grant = '0;
    if (state == ST_IDLE && en) begin
      if (pend[B_QU]) begin
        grant[B_QU] = 1'b1;
      end else if (pend[B_DI]) begin
        grant[B_DI] = 1'b1;
      end else if (pend[B_NI]) begin
        grant[B_NI] = 1'b1;
      end else if (pend[B_SODA]) begin
        grant[B_SODA] = 1'b1;
      end else if (pend[B_DIET]) begin
        grant[B_DIET] = 1'b1;
      end
    end
  end

  assign ni   = pulse[B_NI];
  assign di   = pulse[B_DI];
  assign qu   = pulse[B_QU];
  assign soda = pulse[B_SODA];
  assign diet = pulse[B_DIET];

endmodule

// File: tb/tb_vend_input_cond.sv
// tb_vend_input_cond: directed bench for vend_input_cond. One instance uses
// the default parameters; a second one (short debounce, 15-cycle gap) is used
// for the dropped-press scenario. Output vectors are written {qu,di,ni,soda,diet}.
module tb_vend_input_cond;

  logic CLK;
  logic rst;
  logic en;
  logic btn_ni, btn_di, btn_qu, btn_soda, btn_diet;
  logic ni, di, qu, soda, diet, lost;
  logic b2_ni, b2_di, b2_qu, b2_soda, b2_diet;
  logic ni2, di2, qu2, soda2, diet2, lost2;

  int n_cmp = 0;
  int n_bad = 0;

  vend_input_cond dut (
    .CLK(CLK), .rst(rst),
    .btn_ni(btn_ni), .btn_di(btn_di), .btn_qu(btn_qu),
    .btn_soda(btn_soda), .btn_diet(btn_diet), .en(en),
    .ni(ni), .di(di), .qu(qu), .soda(soda), .diet(diet), .lost(lost)
  );

  vend_input_cond #(.DB_CYCLES(4), .CNT_W(5), .GAP_CYCLES(15)) dut2 (
    .CLK(CLK), .rst(rst),
    .btn_ni(b2_ni), .btn_di(b2_di), .btn_qu(b2_qu),
    .btn_soda(b2_soda), .btn_diet(b2_diet), .en(en),
    .ni(ni2), .di(di2), .qu(qu2), .soda(soda2), .diet(diet2), .lost(lost2)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Absolute time bound so the run always ends
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Advance to 1 time unit past the next rising edge
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    #3;
    n_cmp++;
    if ({qu, di, ni, soda, diet, lost} !== 6'b0) begin
      n_bad++;
      $display("[TB] FAIL reset_async: got %b expected %b", {qu, di, ni, soda, diet, lost}, 6'b0);
    end
    tick();
    tick();
    n_cmp++;
    if ({qu2, di2, ni2, soda2, diet2, lost2} !== 6'b0) begin
      n_bad++;
      $display("[TB] FAIL reset_held: got %b expected %b", {qu2, di2, ni2, soda2, diet2, lost2}, 6'b0);
    end
    rst = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
    end
    n_cmp++;
    if ({qu, di, ni, soda, diet, lost} !== 6'b0) begin
      n_bad++;
      $display("[TB] FAIL reset_idle: got %b expected %b", {qu, di, ni, soda, diet, lost}, 6'b0);
    end
  endtask

  task automatic test_single_press();
    logic [4:0] exp;
    btn_qu = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      tick();
      exp = (k == 19) ? 5'b10000 : 5'b00000;
      n_cmp++;
      if ({qu, di, ni, soda, diet} !== exp) begin
        n_bad++;
        $display("[TB] FAIL single_press edge %0d: got %b expected %b", k, {qu, di, ni, soda, diet}, exp);
      end
    end
    n_cmp++;
    if (lost !== 1'b0) begin
      n_bad++;
      $display("[TB] FAIL single_press_lost: got %b expected 0", lost);
    end
    btn_qu = 1'b0;
    for (int k = 1; k <= 25; k++) begin
      tick();
      n_cmp++;
      if ({qu, di, ni, soda, diet} !== 5'b0) begin
        n_bad++;
        $display("[TB] FAIL release_quiet edge %0d: got %b expected 00000", k, {qu, di, ni, soda, diet});
      end
    end
  endtask

  task automatic test_bounce();
    logic [4:0] exp;
    // Highs of 5 and lows of 3 cycles; final stable rise at cycle 56
    for (int c = 0; c < 100; c++) begin
      btn_di = (c >= 56) ? 1'b1 : ((c % 8) < 5);
      tick();
      exp = ((c + 1) == 75) ? 5'b01000 : 5'b00000;
      n_cmp++;
      if ({qu, di, ni, soda, diet} !== exp) begin
        n_bad++;
        $display("[TB] FAIL bounce edge %0d: got %b expected %b", c + 1, {qu, di, ni, soda, diet}, exp);
      end
    end
    btn_di = 1'b0;
    for (int k = 0; k < 25; k++) begin
      tick();
    end
  endtask

  task automatic test_simultaneous();
    logic [4:0] exp;
    btn_ni   = 1'b1;
    btn_qu   = 1'b1;
    btn_diet = 1'b1;
    for (int k = 1; k <= 35; k++) begin
      tick();
      case (k)
        19:      exp = 5'b10000;
        22:      exp = 5'b00100;
        25:      exp = 5'b00001;
        default: exp = 5'b00000;
      endcase
      n_cmp++;
      if ({qu, di, ni, soda, diet} !== exp) begin
        n_bad++;
        $display("[TB] FAIL simultaneous edge %0d: got %b expected %b", k, {qu, di, ni, soda, diet}, exp);
      end
    end
    btn_ni   = 1'b0;
    btn_qu   = 1'b0;
    btn_diet = 1'b0;
    for (int k = 0; k < 25; k++) begin
      tick();
    end
  endtask

  task automatic test_enable();
    en       = 1'b0;
    btn_soda = 1'b1;
    for (int c = 0; c < 70; c++) begin
      en = (c >= 25);
      tick();
      n_cmp++;
      if ({qu, di, ni, soda, diet} !== 5'b0) begin
        n_bad++;
        $display("[TB] FAIL enable_gate edge %0d: got %b expected 00000", c + 1, {qu, di, ni, soda, diet});
      end
    end
    n_cmp++;
    if (lost !== 1'b0) begin
      n_bad++;
      $display("[TB] FAIL enable_lost: got %b expected 0", lost);
    end
    btn_soda = 1'b0;
    for (int k = 0; k < 25; k++) begin
      tick();
    end
  endtask

  task automatic test_lost();
    logic [4:0] exp;
    logic       exp_lost;
    // Second instance: debounce 4, gap 15. qu granted at edge 7, ni waits
    // until edge 23; ni is released for cycles 8..11 and re-rises at edge 18
    b2_qu = 1'b1;
    for (int c = 0; c < 40; c++) begin
      b2_ni = !(c >= 8 && c <= 11);
      tick();
      case (c + 1)
        7:       exp = 5'b10000;
        23:      exp = 5'b00100;
        default: exp = 5'b00000;
      endcase
      exp_lost = ((c + 1) >= 18);
      n_cmp++;
      if ({qu2, di2, ni2, soda2, diet2} !== exp) begin
        n_bad++;
        $display("[TB] FAIL lost_pulses edge %0d: got %b expected %b", c + 1, {qu2, di2, ni2, soda2, diet2}, exp);
      end
      n_cmp++;
      if (lost2 !== exp_lost) begin
        n_bad++;
        $display("[TB] FAIL lost_flag edge %0d: got %b expected %b", c + 1, lost2, exp_lost);
      end
    end
    b2_qu = 1'b0;
    b2_ni = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      n_cmp++;
      if ({qu2, di2, ni2, soda2, diet2, lost2} !== 6'b000001) begin
        n_bad++;
        $display("[TB] FAIL lost_release edge %0d: got %b expected 000001", k, {qu2, di2, ni2, soda2, diet2, lost2});
      end
    end
  endtask

  task automatic test_async_reset();
    logic [4:0] exp;
    btn_diet = 1'b1;
    for (int k = 0; k < 12; k++) begin
      tick();
    end
    n_cmp++;
    if (lost2 !== 1'b1) begin
      n_bad++;
      $display("[TB] FAIL pre_reset_lost: got %b expected 1", lost2);
    end
    // Debounce count is 10 here; drop reset between edges
    #2;
    rst = 1'b0;
    #1;
    n_cmp++;
    if ({qu, di, ni, soda, diet, lost, lost2} !== 7'b0) begin
      n_bad++;
      $display("[TB] FAIL async_reset_clear: got %b expected 0000000", {qu, di, ni, soda, diet, lost, lost2});
    end
    tick();
    tick();
    rst = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      tick();
      exp = (k == 19) ? 5'b00001 : 5'b00000;
      n_cmp++;
      if ({qu, di, ni, soda, diet} !== exp) begin
        n_bad++;
        $display("[TB] FAIL reset_release edge %0d: got %b expected %b", k, {qu, di, ni, soda, diet}, exp);
      end
    end
    btn_diet = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
    end
  endtask

  // Test sequence
  initial begin
    rst      = 1'b0;
    en       = 1'b1;
    btn_ni   = 1'b0;
    btn_di   = 1'b0;
    btn_qu   = 1'b0;
    btn_soda = 1'b0;
    btn_diet = 1'b0;
    b2_ni    = 1'b0;
    b2_di    = 1'b0;
    b2_qu    = 1'b0;
    b2_soda  = 1'b0;
    b2_diet  = 1'b0;
    $display("[TB] starting vend_input_cond bench");
    test_reset();
    test_single_press();
    test_bounce();
    test_simultaneous();
    test_enable();
    test_lost();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
